a2b_req_sched: RTL and testbench

- Shares one pipelined masked arithmetic-to-Boolean converter core (3×SecCSA + SecKSA, n shares) between NREQ requesters.
- Arbitrates round-robin, gates each issue on availability of a fresh randomness word, and drives the core's dvld/ena.
- Tracks requester IDs through the fixed core latency and returns each masked Boolean result on a single tagged response port with backpressure.
- Provides a flush/drain sequence for mask-refresh or key-change boundaries.

---
 rtl/a2b_req_sched.sv | 163 ++++++++++++++++
 tb/tb_a2b_req_sched.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/a2b_req_sched.sv
// Round-robin scheduler sharing one pipelined masked A2B converter core between NREQ requesters.
// Each issue consumes a fresh randomness word; a tag pipe tracks requester IDs through the core latency.
module a2b_req_sched #(
    parameter int K_WIDTH   = 32,
    parameter int N_SHARES  = 5,
    parameter int MASKWIDTH = K_WIDTH * N_SHARES,
    parameter int NREQ      = 4,
    parameter int CORE_LAT  = 15,
    parameter int IDW       = $clog2(NREQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NREQ-1:0]           req_vld,
    input  logic [NREQ*MASKWIDTH-1:0] req_a,
    output logic [NREQ-1:0]           req_rdy,
    input  logic                      rnd_vld,
    output logic                      rnd_rdy,
    output logic                      core_dvld,
    output logic                      core_ena,
    output logic [MASKWIDTH-1:0]      core_a,
    input  logic                      core_ovld,
    input  logic [MASKWIDTH-1:0]      core_z,
    output logic                      rsp_vld,
    output logic [IDW-1:0]            rsp_id,
    output logic [MASKWIDTH-1:0]      rsp_z,
    input  logic                      rsp_rdy,
    input  logic                      flush,
    output logic                      flush_done,
    output logic                      busy,
    output logic                      tag_err
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam int         INFW     = $clog2(CORE_LAT + 2);

    logic [1:0]           r_state;
    logic [IDW-1:0]       r_ptr;
    logic [CORE_LAT-1:0]  r_tag_v;
    logic [IDW-1:0]       r_tag_id [CORE_LAT];
    logic                 r_rsp_vld;
    logic [IDW-1:0]       r_rsp_id;
    logic [MASKWIDTH-1:0] r_rsp_z;
    logic [INFW-1:0]      r_inflight;
    logic                 r_tag_err;

    logic                 w_out_free;
    logic                 w_issue;
    logic                 w_hs;
    logic                 w_drained;
    logic [IDW-1:0]       w_gid;
    logic [IDW-1:0]       w_next_ptr;
    logic [IDW:0]         w_idx;

    assign w_out_free = !r_rsp_vld || rsp_rdy;
    assign w_hs       = r_rsp_vld && rsp_rdy;
    assign w_drained  = (r_state == ST_DRAIN) && (r_inflight == '0);
    // Gating on rst_n keeps a reset cycle from issuing an operation that the reset then discards.
    assign w_issue    = rst_n && w_out_free && rnd_vld && (r_state == ST_RUN) && !flush && (|req_vld);

    // Scanning downward means the last hit is the nearest requester at or after the pointer.
    always_comb begin
        w_gid = '0;
        w_idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_idx = {1'b0, r_ptr} + (IDW+1)'(k);
            if (w_idx >= (IDW+1)'(NREQ)) begin
                w_idx = w_idx - (IDW+1)'(NREQ);
            end
            if (req_vld[w_idx[IDW-1:0]]) begin
                w_gid = w_idx[IDW-1:0];
            end
        end
    end

    assign w_next_ptr = (w_gid == IDW'(NREQ - 1)) ? '0 : w_gid + IDW'(1);

    assign req_rdy    = w_issue ? (NREQ'(1) << w_gid) : '0;
    assign rnd_rdy    = w_issue;
    assign core_dvld  = w_issue;
    assign core_ena   = w_out_free;
    assign core_a     = w_issue ? req_a[w_gid*MASKWIDTH +: MASKWIDTH] : '0;
    assign rsp_vld    = r_rsp_vld;
    assign rsp_id     = r_rsp_id;
    assign rsp_z      = r_rsp_z;
    assign flush_done = w_drained;
    assign busy       = (r_state != ST_IDLE) || (r_inflight != '0);
    assign tag_err    = r_tag_err;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:  if (!flush)    r_state <= ST_RUN;
                ST_RUN:   if (flush)     r_state <= ST_DRAIN;
                ST_DRAIN: if (w_drained) r_state <= ST_IDLE;
                default:                 r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (w_issue) begin
            r_ptr <= w_next_ptr;
        end
    end

    // The tag pipe mirrors the core pipeline, so it advances only on core_ena.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tag_v <= '0;
            for (int s = 0; s < CORE_LAT; s++) begin
                r_tag_id[s] <= '0;
            end
        end else if (core_ena) begin
            for (int s = CORE_LAT - 1; s > 0; s--) begin
                r_tag_v[s]  <= r_tag_v[s-1];
                r_tag_id[s] <= r_tag_id[s-1];
            end
            r_tag_v[0]  <= w_issue;
            r_tag_id[0] <= w_gid;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rsp_vld <= 1'b0;
            r_rsp_id  <= '0;
            r_rsp_z   <= '0;
        end else if (core_ena && r_tag_v[CORE_LAT-1]) begin
            r_rsp_vld <= 1'b1;
            r_rsp_id  <= r_tag_id[CORE_LAT-1];
            r_rsp_z   <= core_z;
        end else if (rsp_rdy) begin
            r_rsp_vld <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tag_err <= 1'b0;
        end else if (core_ena && (core_ovld != r_tag_v[CORE_LAT-1])) begin
            r_tag_err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_inflight <= '0;
        end else begin
            case ({w_issue, w_hs})
                2'b10:   r_inflight <= r_inflight + INFW'(1);
                2'b01:   r_inflight <= r_inflight - INFW'(1);
                default: r_inflight <= r_inflight;
            endcase
        end
    end

endmodule

// File: tb/tb_a2b_req_sched.sv
// Scoreboard bench for a2b_req_sched with a behavioural A2B core model.
// Issues push expected {id, arithmetic sum}; a separate monitor pops on each response handshake.
module tb_a2b_req_sched;

    localparam int KW  = 32;
    localparam int NS  = 5;
    localparam int MW  = KW * NS;
    localparam int NR  = 4;
    localparam int LAT = 15;
    localparam int IW  = 2;

    typedef struct packed {
        logic [IW-1:0] id;
        logic [KW-1:0] val;
    } sbEntry_t;

    logic             clk;
    logic             rst_n;
    logic [NR-1:0]    req_vld;
    logic [NR*MW-1:0] req_a;
    logic [NR-1:0]    req_rdy;
    logic             rnd_vld;
    logic             rnd_rdy;
    logic             core_dvld;
    logic             core_ena;
    logic [MW-1:0]    core_a;
    logic             core_ovld;
    logic [MW-1:0]    core_z;
    logic             rsp_vld;
    logic [IW-1:0]    rsp_id;
    logic [MW-1:0]    rsp_z;
    logic             rsp_rdy;
    logic             flush;
    logic             flush_done;
    logic             busy;
    logic             tag_err;

    int nVec = 0;
    int nErr = 0;
    int cyc = 0;
    int issueCount = 0;
    int rspCount = 0;
    int mPtr = 0;
    int monG;
    sbEntry_t sbQ[$];
    sbEntry_t popped;

    logic          cmV [LAT];
    logic [MW-1:0] cmZ [LAT];

    a2b_req_sched #(
        .K_WIDTH(KW), .N_SHARES(NS), .MASKWIDTH(MW), .NREQ(NR), .CORE_LAT(LAT), .IDW(IW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req_vld(req_vld), .req_a(req_a), .req_rdy(req_rdy),
        .rnd_vld(rnd_vld), .rnd_rdy(rnd_rdy), .core_dvld(core_dvld), .core_ena(core_ena),
        .core_a(core_a), .core_ovld(core_ovld), .core_z(core_z), .rsp_vld(rsp_vld),
        .rsp_id(rsp_id), .rsp_z(rsp_z), .rsp_rdy(rsp_rdy), .flush(flush),
        .flush_done(flush_done), .busy(busy), .tag_err(tag_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [KW-1:0] sumShares(input logic [MW-1:0] a);
        logic [KW-1:0] s;
        s = '0;
        for (int i = 0; i < NS; i++) s = s + a[i*KW +: KW];
        return s;
    endfunction

    function automatic logic [KW-1:0] xorShares(input logic [MW-1:0] z);
        logic [KW-1:0] s;
        s = '0;
        for (int i = 0; i < NS; i++) s = s ^ z[i*KW +: KW];
        return s;
    endfunction

    // Boolean re-masking with fresh random shares, as the real core would produce.
    function automatic logic [MW-1:0] toBoolean(input logic [MW-1:0] a);
        logic [MW-1:0] z;
        logic [KW-1:0] acc;
        z = '0;
        acc = sumShares(a);
        for (int i = 1; i < NS; i++) begin
            z[i*KW +: KW] = $urandom;
            acc = acc ^ z[i*KW +: KW];
        end
        z[KW-1:0] = acc;
        return z;
    endfunction

    function automatic int rrPick(input logic [NR-1:0] v, input int ptr);
        for (int k = 0; k < NR; k++) begin
            if (v[(ptr + k) % NR]) return (ptr + k) % NR;
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int s = 0; s < LAT; s++) begin
                cmV[s] <= 1'b0;
                cmZ[s] <= '0;
            end
        end else if (core_ena) begin
            for (int s = LAT - 1; s > 0; s--) begin
                cmV[s] <= cmV[s-1];
                cmZ[s] <= cmZ[s-1];
            end
            cmV[0] <= core_dvld;
            cmZ[0] <= toBoolean(core_a);
        end
    end
    assign core_ovld = cmV[LAT-1];
    assign core_z    = cmZ[LAT-1];

    task automatic checkOutput(input string name, input logic [MW-1:0] act, input logic [MW-1:0] exp);
        nVec++;
        if (act !== exp) begin
            nErr++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic applyStimulus(input logic [NR-1:0] vld, input logic rnd, input logic rdy, input logic fl);
        @(posedge clk);
        #1;
        req_vld = vld;
        rnd_vld = rnd;
        rsp_rdy = rdy;
        flush   = fl;
        for (int i = 0; i < NR * NS; i++) req_a[i*KW +: KW] = $urandom;
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, " rsp_vld"}, rsp_vld, 0);
        checkOutput({tag, " req_rdy"}, req_rdy, 0);
        checkOutput({tag, " rnd_rdy"}, rnd_rdy, 0);
        checkOutput({tag, " core_dvld"}, core_dvld, 0);
        checkOutput({tag, " core_a"}, core_a, 0);
        checkOutput({tag, " flush_done"}, flush_done, 0);
        checkOutput({tag, " tag_err"}, tag_err, 0);
        checkOutput({tag, " busy"}, busy, 0);
    endtask

    task automatic waitDrain(input string name);
        int k;
        for (k = 0; k < 100; k++) begin
            @(negedge clk);
            if (sbQ.size() == 0 && !rsp_vld) break;
        end
        checkOutput({name, " drain finished"}, k < 100, 1);
    endtask

    // Issue monitor: predicts the round-robin grant and pushes the expected response.
    always @(negedge clk) begin
        if (!rst_n) begin
            sbQ.delete();
            mPtr = 0;
        end else begin
            checkOutput("rnd_rdy equals core_dvld", rnd_rdy, core_dvld);
            if (!rnd_vld || !core_ena) checkOutput("no issue without rnd/ena", core_dvld, 0);
            if (core_dvld) begin
                monG = rrPick(req_vld, mPtr);
                if (monG < 0) begin
                    checkOutput("issue without request", core_dvld, 0);
                end else begin
                    checkOutput("grant onehot", req_rdy, NR'(1) << monG);
                    checkOutput("core_a operand", core_a, req_a[monG*MW +: MW]);
                    sbQ.push_back('{id: IW'(monG), val: sumShares(req_a[monG*MW +: MW])});
                    issueCount++;
                    mPtr = (monG + 1) % NR;
                end
            end else begin
                checkOutput("no grant without issue", req_rdy, 0);
            end
        end
    end

    // Response monitor: pops one expectation per handshake.
    always @(negedge clk) begin
        if (rst_n && rsp_vld && rsp_rdy) begin
            rspCount++;
            if (sbQ.size() == 0) begin
                checkOutput("unexpected response", 1, 0);
            end else begin
                popped = sbQ.pop_front();
                checkOutput("rsp_id", rsp_id, popped.id);
                checkOutput("rsp_z xor equals arithmetic sum", xorShares(rsp_z), popped.val);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int k, lat, issueCyc, snapIssue, snapRsp, hs, hsCyc, cnt, stale;
        logic [IW-1:0] heldId;
        logic [MW-1:0] heldZ;
        logic [NR-1:0] rotExp [8];
        rotExp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};

        rst_n = 1'b0; req_vld = '0; req_a = '0; rnd_vld = 1'b0; rsp_rdy = 1'b1; flush = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkResetOutputs("reset");
        @(posedge clk); #1; rst_n = 1'b1;
        applyStimulus(4'b0000, 1'b1, 1'b1, 1'b0);
        applyStimulus(4'b0000, 1'b1, 1'b1, 1'b0);

        $display("[TB] round-robin rotation with all requesters");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(4'b1111, 1'b1, 1'b1, 1'b0);
            @(negedge clk);
            checkOutput("rotation grant", req_rdy, rotExp[i]);
        end
        applyStimulus(4'b0000, 1'b1, 1'b1, 1'b0);
        waitDrain("rotation");

        $display("[TB] single request from requester 2");
        applyStimulus(4'b0100, 1'b1, 1'b1, 1'b0);
        req_a[2*MW +: MW] = {32'hF000_0000, 32'd4, 32'd3, 32'd2, 32'h1000_0001};
        @(negedge clk);
        checkOutput("single grant", req_rdy, 4'b0100);
        issueCyc = cyc;
        applyStimulus(4'b0000, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("grant lasts one cycle", req_rdy, 4'b0000);
        for (k = 0; k < 40; k++) begin
            if (rsp_vld) break;
            @(negedge clk);
        end
        lat = cyc - issueCyc;
        checkOutput("single latency", lat, 16);
        checkOutput("single rsp_id", rsp_id, 2);
        checkOutput("single xor wraps mod 2^32", xorShares(rsp_z), 32'h0000_000A);
        waitDrain("single");

        $display("[TB] response stall of 5 cycles");
        snapIssue = issueCount; snapRsp = rspCount;
        repeat (20) applyStimulus(4'b1111, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(4'b1111, 1'b1, 1'b0, 1'b0);
            @(negedge clk);
            checkOutput("stall core_ena", core_ena, 0);
            checkOutput("stall rsp_vld held", rsp_vld, 1);
            if (i == 0) begin
                heldId = rsp_id;
                heldZ = rsp_z;
            end else if (i == 4) begin
                checkOutput("stall rsp_id stable", rsp_id, heldId);
                checkOutput("stall rsp_z stable", rsp_z, heldZ);
            end
        end
        applyStimulus(4'b0000, 1'b1, 1'b1, 1'b0);
        waitDrain("stall");
        checkOutput("stall issue count", issueCount - snapIssue, 20);
        checkOutput("stall responses equal issues", rspCount - snapRsp, issueCount - snapIssue);

        $display("[TB] randomness toggling");
        snapIssue = issueCount;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(4'b1111, (i % 2) == 0, 1'b1, 1'b0);
            @(negedge clk);
            checkOutput("issue follows rnd_vld", core_dvld, rnd_vld);
        end
        applyStimulus(4'b0000, 1'b1, 1'b1, 1'b0);
        waitDrain("rnd toggle");
        checkOutput("rnd toggle issue count", issueCount - snapIssue, 4);

        $display("[TB] flush with three operations in flight");
        snapIssue = issueCount;
        repeat (3) applyStimulus(4'b1111, 1'b1, 1'b1, 1'b0);
        applyStimulus(4'b1111, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        checkOutput("no issue on flush cycle", core_dvld, 0);
        hs = 0; hsCyc = 0;
        for (k = 0; k < 60; k++) begin
            @(negedge clk);
            if (flush_done) break;
            if (rsp_vld && rsp_rdy) begin
                hs++;
                hsCyc = cyc;
            end
        end
        checkOutput("flush_done seen", k < 60, 1);
        checkOutput("flush handshakes", hs, 3);
        checkOutput("flush_done one cycle after last handshake", cyc - hsCyc, 1);
        checkOutput("busy during flush_done", busy, 1);
        checkOutput("no issue while draining", issueCount - snapIssue, 3);
        @(negedge clk);
        checkOutput("flush_done is a pulse", flush_done, 0);
        checkOutput("busy falls after drain", busy, 0);
        cnt = 0;
        repeat (3) begin
            @(negedge clk);
            if (core_dvld) cnt++;
        end
        checkOutput("no issue while flush held", cnt, 0);
        applyStimulus(4'b1111, 1'b1, 1'b1, 1'b0);
        for (k = 0; k < 5; k++) begin
            @(negedge clk);
            if (core_dvld) break;
        end
        checkOutput("issue resumes after flush", k < 5, 1);
        applyStimulus(4'b0000, 1'b1, 1'b1, 1'b0);
        waitDrain("flush");

        $display("[TB] reset mid-stream");
        repeat (10) applyStimulus(4'b1111, 1'b1, 1'b1, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b0; req_vld = '0; rnd_vld = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1; rnd_vld = 1'b1;
        @(negedge clk);
        checkResetOutputs("mid reset");
        stale = 0;
        repeat (30) begin
            @(negedge clk);
            if (rsp_vld) stale++;
        end
        checkOutput("no stale rsp after reset", stale, 0);
        applyStimulus(4'b0001, 1'b1, 1'b1, 1'b0);
        applyStimulus(4'b0000, 1'b1, 1'b1, 1'b0);
        waitDrain("post reset");

        checkOutput("tag_err stays clear", tag_err, 0);
        checkOutput("scoreboard empty", sbQ.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
